// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared definitions for the load/store unit: access-size
//               encodings, FSM state encoding, big-endian lane offsets and
//               the alignment-fault helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // Access size encodings carried on req_size
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_EXT   = 3'd2,
    ST_MERGE = 3'd3,
    ST_WR    = 3'd4,
    ST_RESP  = 3'd5
  } lsu_state_t;

  // Big-endian byte lanes: offset 0 is the most significant byte
  localparam logic [1:0] OFF_B0 = 2'd0;  // [31:24]
  localparam logic [1:0] OFF_B1 = 2'd1;  // [23:16]
  localparam logic [1:0] OFF_B2 = 2'd2;  // [15:8]
  localparam logic [1:0] OFF_B3 = 2'd3;  // [7:0]
  localparam logic [1:0] OFF_H0 = 2'd0;  // [31:16]
  localparam logic [1:0] OFF_H2 = 2'd2;  // [15:0]

  // Alignment fault: odd halfword, non-word-aligned word, or reserved size
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = (offset != 2'b00);
      SZ_RSVD: bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane_align
// Description : Combinational lane logic for the load/store unit.
//               Load side : pick the addressed byte/half/word out of rd_word
//                           and zero- or sign-extend it.
//               Store side: replace the addressed lane(s) of rd_word (the old
//                           memory word) with right-justified st_data.
// Ports       : rd_word   in  32  word read from memory (also the old word)
//               st_data   in  32  right-justified store data
//               offset    in   2  byte offset within the word
//               size      in   2  access size encoding
//               sign_ext  in   1  sign-extend sub-word loads
//               ld_result out 32  extended load value
//               st_merged out 32  word with new lane(s) merged in
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] st_data,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] ld_result,
  output logic [31:0] st_merged
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = rd_word[7:0];
    case (offset)
      OFF_B0:  lane_byte = rd_word[31:24];
      OFF_B1:  lane_byte = rd_word[23:16];
      OFF_B2:  lane_byte = rd_word[15:8];
      OFF_B3:  lane_byte = rd_word[7:0];
      default: lane_byte = rd_word[7:0];
    endcase
  end

  // Aligned halfwords only ever sit at offset 0 or 2, so bit 1 selects
  always_comb begin
    lane_half = (offset[1] == OFF_H2[1]) ? rd_word[15:0] : rd_word[31:16];
  end

  always_comb begin
    ld_result = rd_word;
    case (size)
      SZ_BYTE: ld_result = {{24{sign_ext & lane_byte[7]}}, lane_byte};
      SZ_HALF: ld_result = {{16{sign_ext & lane_half[15]}}, lane_half};
      default: ld_result = rd_word;
    endcase
  end

  always_comb begin
    st_merged = rd_word;
    case (size)
      SZ_BYTE: begin
        case (offset)
          OFF_B0:  st_merged[31:24] = st_data[7:0];
          OFF_B1:  st_merged[23:16] = st_data[7:0];
          OFF_B2:  st_merged[15:8]  = st_data[7:0];
          default: st_merged[7:0]   = st_data[7:0];
        endcase
      end
      SZ_HALF: begin
        if (offset[1] == OFF_H0[1]) begin
          st_merged[31:16] = st_data[15:0];
        end else begin
          st_merged[15:0] = st_data[15:0];
        end
      end
      SZ_WORD: st_merged = st_data;
      default: st_merged = rd_word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Initiator side of the word-wide data-memory interface.
//               Provides lb/lbu/lh/lhu/lw/sb/sh/sw on a word-only memory;
//               sub-word stores are done as read-modify-write.
//               Optional macro LSU_RANGE_CHECK_EN enables an address range
//               fault (word index >= MEM_WORDS) raised at accept.
// Ports       : clk, rst            clock / synchronous active-high reset
//               req_valid/req_ready request handshake
//               req_write, req_size, req_signed, req_addr, req_wdata
//               resp_valid          one-cycle completion pulse
//               resp_rdata          load result (0 for stores and faults)
//               resp_misaligned     alignment / reserved-size fault
//               resp_fault          address range fault
//               MemRead, MemWrite, Address, Write_data  to data memory
//               ReadData            from data memory (one cycle after MemRead)
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_fault,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Address,
  output logic [31:0] Write_data,
  input  logic [31:0] ReadData
);

  lsu_state_t  state;

  // Request captured at accept
  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  offset_q;
  logic [31:0] wdata_q;

  logic        mem_read_q;
  logic        mem_write_q;
  logic        fault_q;

  logic        misaligned;
  logic        range_bad;
  logic [31:0] ld_result;
  logic [31:0] st_merged;

  assign misaligned = is_misaligned(req_size, req_addr[1:0]);

`ifdef LSU_RANGE_CHECK_EN
  assign range_bad = ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
`else
  // Without the range check fault_q never sets, so resp_fault stays 0
  assign range_bad = 1'b0;
`endif

  // Strobes and ready are masked by rst so a reset asserted while a
  // strobe is registered high never reaches the memory
  assign MemRead    = mem_read_q  & ~rst;
  assign MemWrite   = mem_write_q & ~rst;
  assign req_ready  = (state == ST_IDLE) & ~rst;
  assign resp_fault = fault_q;

  lsu_lane_align u_lane_align (
    .rd_word   (ReadData),
    .st_data   (wdata_q),
    .offset    (offset_q),
    .size      (size_q),
    .sign_ext  (signed_q),
    .ld_result (ld_result),
    .st_merged (st_merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      write_q         <= 1'b0;
      size_q          <= SZ_BYTE;
      signed_q        <= 1'b0;
      offset_q        <= 2'b00;
      wdata_q         <= 32'h0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      fault_q         <= 1'b0;
      resp_valid      <= 1'b0;
      resp_rdata      <= 32'h0;
      resp_misaligned <= 1'b0;
      Address         <= 32'h0;
      Write_data      <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            write_q  <= req_write;
            size_q   <= req_size;
            signed_q <= req_signed;
            offset_q <= req_addr[1:0];
            wdata_q  <= req_wdata;
            Address  <= {req_addr[31:2], 2'b00};
            // Alignment faults win over range faults
            if (misaligned) begin
              resp_misaligned <= 1'b1;
              resp_rdata      <= 32'h0;
              resp_valid      <= 1'b1;
              state           <= ST_RESP;
            end else if (range_bad) begin
              fault_q    <= 1'b1;
              resp_rdata <= 32'h0;
              resp_valid <= 1'b1;
              state      <= ST_RESP;
            end else if (req_write && (req_size == SZ_WORD)) begin
              // Full-word store needs no read of the old contents
              Write_data  <= req_wdata;
              mem_write_q <= 1'b1;
              state       <= ST_WR;
            end else begin
              mem_read_q <= 1'b1;
              state      <= ST_RD;
            end
          end
        end
        ST_RD: begin
          mem_read_q <= 1'b0;
          state      <= write_q ? ST_MERGE : ST_EXT;
        end
        ST_EXT: begin
          resp_rdata <= ld_result;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_MERGE: begin
          Write_data  <= st_merged;
          mem_write_q <= 1'b1;
          state       <= ST_WR;
        end
        ST_WR: begin
          mem_write_q <= 1'b0;
          resp_rdata  <= 32'h0;
          resp_valid  <= 1'b1;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          resp_valid      <= 1'b0;
          resp_misaligned <= 1'b0;
          fault_q         <= 1'b0;
          resp_rdata      <= 32'h0;
          state           <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
